// File: rtl/simmem_pkg.sv
// Shared definitions for the simulated-memory response path.
package simmem_pkg;

  localparam int unsigned DefDataWidth = 64;
  localparam int unsigned DefNumIds    = 16;
  localparam int unsigned DefCapacity  = 64;
  localparam int unsigned DefPtrWidth  = $clog2(DefCapacity);
  localparam int unsigned DefCntWidth  = $clog2(DefCapacity) + 1;

endpackage

// File: rtl/simmem_resp_bank_if.sv
// Input/output handshake bundle of the response bank.
interface simmem_resp_bank_if
  import simmem_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned NumIds    = DefNumIds,
  parameter int unsigned IdWidth   = $clog2(NumIds)
);

  logic [NumIds-1:0]    release_en_i;
  logic [IdWidth-1:0]   in_id_i;
  logic [DataWidth-1:0] in_data_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [IdWidth-1:0]   out_id_o;
  logic [DataWidth-1:0] out_data_o;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [NumIds-1:0]    id_empty_o;

  modport slave (
    input  release_en_i, in_id_i, in_data_i, in_valid_i, out_ready_i,
    output in_ready_o, out_id_o, out_data_o, out_valid_o, id_empty_o
  );

  modport master (
    output release_en_i, in_id_i, in_data_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_id_o, out_data_o, out_valid_o, id_empty_o
  );

endinterface

// File: rtl/simmem_bank_mem.sv
// Flop-array payload storage: one write port, one asynchronous read port.
module simmem_bank_mem
  import simmem_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned Capacity  = DefCapacity,
  parameter int unsigned PtrWidth  = $clog2(Capacity)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [PtrWidth-1:0]  wr_addr,
  input  logic [DataWidth-1:0] wr_data,
  input  logic [PtrWidth-1:0]  rd_addr,
  output logic [DataWidth-1:0] rd_data
);

  logic [DataWidth-1:0] mem [Capacity];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/simmem_resp_bank.sv
// Multi-ID response bank: shared pool, per-ID linked lists, round-robin release.
module simmem_resp_bank
  import simmem_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned NumIds    = DefNumIds,
  parameter int unsigned IdWidth   = $clog2(NumIds),
  parameter int unsigned Capacity  = DefCapacity
) (
  input logic               clk_i,
  input logic               rst_i,
  simmem_resp_bank_if.slave bus
);

  localparam int unsigned PtrW = $clog2(Capacity);
  localparam int unsigned CntW = $clog2(Capacity) + 1;

  logic [PtrW-1:0]      head_q [NumIds];
  logic [PtrW-1:0]      tail_q [NumIds];
  logic [CntW-1:0]      count_q [NumIds];
  logic [PtrW-1:0]      next_q [Capacity];
  logic [PtrW-1:0]      free_head_q;
  logic [CntW-1:0]      free_cnt_q;
  logic [IdWidth-1:0]   last_grant_q;
  logic                 out_valid_q;
  logic [IdWidth-1:0]   out_id_q;
  logic [DataWidth-1:0] out_data_q;

  logic [NumIds-1:0]    eligible;
  logic [NumIds-1:0]    id_empty;
  logic                 grant_vld;
  logic [IdWidth-1:0]   grant;
  int                   idx;
  logic                 push, pop, push_to_empty;
  logic [PtrW-1:0]      pop_addr, wr_addr;
  logic [DataWidth-1:0] rd_data;

  always_comb begin
    for (int i = 0; i < int'(NumIds); i++) begin
      id_empty[i] = (count_q[i] == '0);
      eligible[i] = !id_empty[i] && bus.release_en_i[i];
    end
  end

  // Round-robin search starts strictly after the previous grant
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int k = 1; k <= int'(NumIds); k++) begin
      idx = (int'(last_grant_q) + k) % int'(NumIds);
      if (!grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant     = IdWidth'(idx);
      end
    end
  end

  assign push     = bus.in_valid_i && (free_cnt_q != '0);
  assign pop      = grant_vld && (!out_valid_q || bus.out_ready_i);
  assign pop_addr = head_q[grant];
  // A concurrent push recycles the popped slot instead of touching the free list
  assign wr_addr  = pop ? pop_addr : free_head_q;
  assign push_to_empty = (count_q[bus.in_id_i] == '0) ||
                         (pop && (grant == bus.in_id_i) && (count_q[grant] == CntW'(1)));

  simmem_bank_mem #(
    .DataWidth (DataWidth),
    .Capacity  (Capacity),
    .PtrWidth  (PtrW)
  ) u_mem (
    .clk     (clk_i),
    .wr_en   (push),
    .wr_addr (wr_addr),
    .wr_data (bus.in_data_i),
    .rd_addr (pop_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Capacity); i++) next_q[i] <= PtrW'((i + 1) % int'(Capacity));
      for (int i = 0; i < int'(NumIds); i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
      free_head_q  <= '0;
      free_cnt_q   <= CntW'(Capacity);
      last_grant_q <= IdWidth'(NumIds - 1);
      out_valid_q  <= 1'b0;
      out_id_q     <= '0;
      out_data_q   <= '0;
    end else begin
      if (push && !pop) begin
        free_head_q <= next_q[free_head_q];
        free_cnt_q  <= free_cnt_q - CntW'(1);
      end else if (pop && !push) begin
        free_head_q      <= pop_addr;
        free_cnt_q       <= free_cnt_q + CntW'(1);
        next_q[pop_addr] <= free_head_q;
      end
      if (push && !push_to_empty) next_q[tail_q[bus.in_id_i]] <= wr_addr;

      for (int i = 0; i < int'(NumIds); i++) begin
        if (push && (bus.in_id_i == IdWidth'(i)) && push_to_empty) head_q[i] <= wr_addr;
        else if (pop && (grant == IdWidth'(i)))                   head_q[i] <= next_q[pop_addr];
        if (push && (bus.in_id_i == IdWidth'(i))) tail_q[i] <= wr_addr;
        count_q[i] <= count_q[i]
                    + {{(CntW-1){1'b0}}, push && (bus.in_id_i == IdWidth'(i))}
                    - {{(CntW-1){1'b0}}, pop && (grant == IdWidth'(i))};
      end

      // Output register: load on grant, otherwise hold until accepted
      if (pop) begin
        out_valid_q  <= 1'b1;
        out_id_q     <= grant;
        out_data_q   <= rd_data;
        last_grant_q <= grant;
      end else if (bus.out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready_o  = (free_cnt_q != '0);
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_id_o    = out_id_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.id_empty_o  = id_empty;

endmodule
